// File: rtl/tdc_capture_ctrl_pkg.sv
// Shared constants for the TDC capture controller: default widths and FSM state encoding.
package tdc_capture_ctrl_pkg;

  localparam int unsigned DEF_COARSE_W    = 24;
  localparam int unsigned DEF_FINE_W      = 6;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DEAD_CYCLES = 4;
  localparam int unsigned DEF_MISS_W      = 8;
  localparam int unsigned TS_W            = DEF_COARSE_W + DEF_FINE_W;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_ARMED   = 3'd1;
  localparam logic [STATE_W-1:0] ST_SAMPLE  = 3'd2;
  localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd3;
  localparam logic [STATE_W-1:0] ST_HOLD    = 3'd4;
  localparam logic [STATE_W-1:0] ST_DEAD    = 3'd5;

  // A measurement is in flight in every state except IDLE and ARMED.
  function automatic logic is_busy(input logic [STATE_W-1:0] st);
    return !((st == ST_IDLE) || (st == ST_ARMED));
  endfunction

endpackage

// File: rtl/tdc_capture_ctrl_edge_sync.sv
// Multi-flop synchroniser for an asynchronous input with a rising-edge detect.
module tdc_capture_ctrl_edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift chain; sync_q[STAGES-1] is the first metastability-safe copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/tdc_capture_ctrl.sv
// Sequences one TDC measurement: edge detect, delay-line sample strobe, coarse/fine latch,
// timestamp handoff on a valid/ready stream, dead time and missed-edge counting.
module tdc_capture_ctrl
  import tdc_capture_ctrl_pkg::*;
#(
  parameter int unsigned COARSE_W    = DEF_COARSE_W,
  parameter int unsigned FINE_W      = DEF_FINE_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter int unsigned MISS_W      = DEF_MISS_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm,
  input  logic                       signal_in,
  input  logic [FINE_W-1:0]          fine_count,
  output logic                       sample,
  output logic                       ts_valid,
  input  logic                       ts_ready,
  output logic [COARSE_W+FINE_W-1:0] ts_data,
  output logic                       busy,
  output logic [MISS_W-1:0]          missed
);

  localparam int unsigned DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  logic                       rise_c;
  logic [STATE_W-1:0]         state_q, state_d;
  logic [COARSE_W-1:0]        coarse_q;
  logic [COARSE_W-1:0]        coarse_lat_q, coarse_lat_d;
  logic [DEAD_W-1:0]          dead_cnt_q, dead_cnt_d;
  logic [MISS_W-1:0]          missed_d;
  logic [COARSE_W+FINE_W-1:0] ts_data_d;
  logic                       sample_d, ts_valid_d, busy_d;

  tdc_capture_ctrl_edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (signal_in),
    .rise_c   (rise_c)
  );

  // Free-running coarse time base; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coarse_q <= '0;
    else        coarse_q <= coarse_q + COARSE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      coarse_lat_q <= '0;
      dead_cnt_q   <= '0;
      missed       <= '0;
      ts_data      <= '0;
      sample       <= 1'b0;
      ts_valid     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      coarse_lat_q <= coarse_lat_d;
      dead_cnt_q   <= dead_cnt_d;
      missed       <= missed_d;
      ts_data      <= ts_data_d;
      sample       <= sample_d;
      ts_valid     <= ts_valid_d;
      busy         <= busy_d;
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_d      = state_q;
    coarse_lat_d = coarse_lat_q;
    dead_cnt_d   = dead_cnt_q;
    missed_d     = missed;
    ts_data_d    = ts_data;
    ts_valid_d   = ts_valid;
    sample_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (rise_c) begin
          state_d      = ST_SAMPLE;
          coarse_lat_d = coarse_q;
          sample_d     = 1'b1;
        end else if (!arm) begin
          state_d = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        ts_data_d  = {coarse_lat_q, fine_count};
        ts_valid_d = 1'b1;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (ts_ready) begin
          ts_valid_d = 1'b0;
          dead_cnt_d = DEAD_W'(DEAD_CYCLES - 1);
          state_d    = ST_DEAD;
        end
      end
      ST_DEAD: begin
        if (dead_cnt_q == '0) state_d = arm ? ST_ARMED : ST_IDLE;
        else                  dead_cnt_d = dead_cnt_q - DEAD_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Edges seen outside ARMED are lost; count them, sticking at all-ones.
    if (rise_c && (state_q != ST_ARMED) && (missed != '1)) begin
      missed_d = missed + MISS_W'(1);
    end

    busy_d = is_busy(state_d);
  end

endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// Scoreboard bench for tdc_capture_ctrl (coarse counter narrowed to 8 bits so wrap is reachable).
module tb_tdc_capture_ctrl;

  localparam int unsigned CW = 8;
  localparam int unsigned FW = 6;
  localparam int unsigned TW = CW + FW;
  localparam int unsigned MW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          signal_in = 1'b0;
  logic          ts_ready = 1'b0;
  logic [FW-1:0] fine_count = '0;
  logic          sample, ts_valid, busy;
  logic [TW-1:0] ts_data;
  logic [MW-1:0] missed;

  logic [CW-1:0] m;
  logic [TW-1:0] sb[$];
  int            errors = 0;
  int            checks = 0;
  int            sample_seen = 0;
  int            accepts = 0;
  int            exp_accepts = 0;
  logic [MW-1:0] exp_missed = '0;

  tdc_capture_ctrl #(
    .COARSE_W    (CW),
    .FINE_W      (FW),
    .SYNC_STAGES (2),
    .DEAD_CYCLES (4),
    .MISS_W      (MW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .signal_in  (signal_in),
    .fine_count (fine_count),
    .sample     (sample),
    .ts_valid   (ts_valid),
    .ts_ready   (ts_ready),
    .ts_data    (ts_data),
    .busy       (busy),
    .missed     (missed)
  );

  always #5 clk = ~clk;

  // Reference time base: what the coarse counter should read in the current cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= m + 8'd1;
  end

  task automatic monitor();
    logic [TW-1:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (sample) sample_seen++;
      if (rst_n && ts_valid && ts_ready) begin
        accepts++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got ts_data=%h, required no timestamp", ts_data);
        end else begin
          exp = sb.pop_front();
          if (ts_data !== exp) begin
            errors++;
            $display("FAIL sb_ts_data: got %h, required %h", ts_data, exp);
          end
        end
      end
    end
  endtask

  // Raise signal_in now; edge cycle is two cycles later, so expect coarse = m + 2.
  task automatic pulse_now(input logic [FW-1:0] fine, input bit expect_ts);
    logic [CW-1:0] c;
    c = m + 8'd2;
    fine_count = fine;
    if (expect_ts) begin
      sb.push_back({c, fine});
      exp_accepts++;
    end
    signal_in = 1'b1;
    repeat (3) @(negedge clk);
    signal_in = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse_at(input logic [CW-1:0] target, input logic [FW-1:0] fine);
    int n;
    n = 0;
    while (m !== target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (m !== target) begin
      checks++;
      errors++;
      $display("FAIL wait_coarse: got m=%0d, required %0d", m, target);
    end else begin
      pulse_now(fine, 1'b1);
    end
  endtask

  task automatic short_pulse();
    signal_in = 1'b1;
    repeat (2) @(negedge clk);
    signal_in = 1'b0;
    repeat (2) @(negedge clk);
    if (exp_missed != 8'hFF) exp_missed = exp_missed + 8'd1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 5;
    if (sample !== 1'b0)   begin errors++; $display("FAIL rst_sample: got %b, required 0", sample); end
    if (ts_valid !== 1'b0) begin errors++; $display("FAIL rst_ts_valid: got %b, required 0", ts_valid); end
    if (ts_data !== '0)    begin errors++; $display("FAIL rst_ts_data: got %h, required 0", ts_data); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (missed !== '0)     begin errors++; $display("FAIL rst_missed: got %0d, required 0", missed); end
    arm = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    int sample_k, nsample, valid_k, n;
    logic [CW-1:0] c;
    n = 0;
    while (m !== 8'd100 && n < 300) begin
      @(negedge clk);
      n++;
    end
    c = m + 8'd2;
    fine_count = 6'd17;
    sb.push_back({c, 6'd17});
    exp_accepts++;
    signal_in = 1'b1;
    sample_k = 0; nsample = 0; valid_k = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (sample) begin nsample++; sample_k = k; end
      if (ts_valid && valid_k == 0) valid_k = k;
      if (k == 4) signal_in = 1'b0;
    end
    checks += 3;
    if (nsample != 1 || sample_k != 3) begin
      errors++;
      $display("FAIL cap_sample: got %0d pulses at k=%0d, required 1 pulse at k=3", nsample, sample_k);
    end
    if (valid_k != 5) begin
      errors++;
      $display("FAIL cap_valid_latency: got k=%0d, required k=5", valid_k);
    end
    if (busy !== 1'b1) begin errors++; $display("FAIL cap_busy: got %b, required 1", busy); end
  endtask

  task automatic test_hold_stall();
    logic [TW-1:0] d0;
    bit stable;
    int dead_seen;
    bit valid_dropped;
    d0 = ts_data;
    stable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) signal_in = 1'b1;
      if (k == 5) signal_in = 1'b0;
      if (!ts_valid || ts_data !== d0) stable = 1'b0;
    end
    exp_missed = exp_missed + 8'd1;
    checks += 2;
    if (!stable) begin errors++; $display("FAIL hold_stable: got valid=%b data=%h, required 1/%h", ts_valid, ts_data, d0); end
    if (missed !== exp_missed) begin errors++; $display("FAIL hold_missed: got %0d, required %0d", missed, exp_missed); end
    ts_ready = 1'b1;
    dead_seen = 0;
    valid_dropped = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        ts_ready = 1'b0;
        valid_dropped = !ts_valid;
      end
      if (busy) dead_seen++;
    end
    checks += 2;
    if (!valid_dropped) begin errors++; $display("FAIL hold_valid_drop: got valid=1, required 0"); end
    if (dead_seen != 4) begin errors++; $display("FAIL dead_cycles: got %0d, required 4", dead_seen); end
  endtask

  task automatic test_wrap();
    ts_ready = 1'b1;
    pulse_at(8'hFC, 6'd63);
    pulse_at(8'hFD, 6'd0);
    pulse_at(8'hFE, 6'd5);
  endtask

  task automatic test_disarm();
    logic [CW-1:0] c;
    int s0;
    ts_ready = 1'b0;
    @(negedge clk);
    c = m + 8'd2;
    fine_count = 6'd40;
    sb.push_back({c, 6'd40});
    exp_accepts++;
    signal_in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3) signal_in = 1'b0;
      if (k == 4) arm = 1'b0;
      if (k == 5) begin
        checks++;
        if (ts_valid !== 1'b1) begin errors++; $display("FAIL disarm_valid: got %b, required 1", ts_valid); end
      end
      if (k == 6) ts_ready = 1'b1;
      if (k == 7) ts_ready = 1'b0;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL disarm_idle: got busy=%b, required 0", busy); end
    s0 = sample_seen;
    repeat (3) short_pulse();
    checks += 2;
    if (missed !== exp_missed) begin errors++; $display("FAIL disarm_missed: got %0d, required %0d", missed, exp_missed); end
    if (sample_seen != s0) begin errors++; $display("FAIL disarm_no_sample: got %0d pulses, required 0", sample_seen - s0); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      short_pulse();
      if (i == 250) begin
        checks++;
        if (missed !== exp_missed) begin errors++; $display("FAIL sat_reach: got %0d, required %0d", missed, exp_missed); end
      end
    end
    checks++;
    if (missed !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %0d, required 255", missed); end
  endtask

  task automatic test_reset_hold();
    int n;
    arm = 1'b1;
    ts_ready = 1'b0;
    repeat (2) @(negedge clk);
    fine_count = 6'd9;
    signal_in = 1'b1;
    n = 0;
    while (!ts_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    signal_in = 1'b0;
    if (!ts_valid) begin
      checks++;
      errors++;
      $display("FAIL rh_wait_valid: got valid=0, required 1");
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (ts_valid !== 1'b0) begin errors++; $display("FAIL rh_valid: got %b, required 0", ts_valid); end
    if (missed !== '0)     begin errors++; $display("FAIL rh_missed: got %0d, required 0", missed); end
    if (sample !== 1'b0)   begin errors++; $display("FAIL rh_sample: got %b, required 0", sample); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL rh_busy: got %b, required 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_missed = '0;
    ts_ready = 1'b1;
    repeat (2) @(negedge clk);
    pulse_now(6'd33, 1'b1);
    checks++;
    if (missed !== '0) begin errors++; $display("FAIL rh_post_missed: got %0d, required 0", missed); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_capture();
    test_hold_stall();
    test_wrap();
    test_disarm();
    test_saturate();
    test_reset_hold();
    repeat (4) @(negedge clk);
    checks += 2;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending, required 0", sb.size()); end
    if (accepts != exp_accepts) begin errors++; $display("FAIL accept_count: got %0d, required %0d", accepts, exp_accepts); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
